bbox_dim_sequencer: RTL and testbench

BBOX_DIM_SEQUENCER -- requirements
Module: bbox_dim_sequencer

---
 rtl/bbox_dim_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_bbox_dim_sequencer.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bbox_dim_sequencer.sv
// Bounding-box extent sequencer: accumulates per-axis signed min/max over a cluster
// of Q16.16 points, then reports saturated extents and the point count.
module bbox_dim_sequencer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pt_valid,
   output logic             pt_ready,
   input  logic [31:0]      pt_x,
   input  logic [31:0]      pt_y,
   input  logic [31:0]      pt_z,
   input  logic             pt_last,
   output logic             dim_valid,
   input  logic             dim_ready,
   output logic [31:0]      dx,
   output logic [31:0]      dy,
   output logic [31:0]      dz,
   output logic [CNT_W-1:0] pt_count,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      CALC  = 2'd2,
      OUT   = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [31:0]      min_x_q, min_y_q, min_z_q, min_x_d, min_y_d, min_z_d;
   logic [31:0]      max_x_q, max_y_q, max_z_q, max_x_d, max_y_d, max_z_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [31:0]      dx_q, dy_q, dz_q, dx_d, dy_d, dz_d;
   logic [CNT_W-1:0] pt_count_q, pt_count_d;
   logic             dim_valid_q, dim_valid_d;
   logic             busy_q;
   logic             accept;

   function automatic logic [31:0] smin(input logic [31:0] a, input logic [31:0] b);
      if ($signed(a) < $signed(b)) begin
         smin = a;
      end else begin
         smin = b;
      end
   endfunction

   function automatic logic [31:0] smax(input logic [31:0] a, input logic [31:0] b);
      if ($signed(a) > $signed(b)) begin
         smax = a;
      end else begin
         smax = b;
      end
   endfunction

   // max >= min always holds, so the 33-bit difference is non-negative; only the top end clips.
   function automatic logic [31:0] extent(input logic [31:0] mx, input logic [31:0] mn);
      logic [32:0] diff;
      diff = {mx[31], mx} - {mn[31], mn};
      if ($signed(diff) > $signed(33'h0_7FFF_FFFF)) begin
         extent = 32'h7FFF_FFFF;
      end else begin
         extent = diff[31:0];
      end
   endfunction

   assign pt_ready  = ~rst & ((state_q == IDLE) | (state_q == ACCUM));
   assign accept    = pt_valid & pt_ready;
   assign dim_valid = dim_valid_q;
   assign dx        = dx_q;
   assign dy        = dy_q;
   assign dz        = dz_q;
   assign pt_count  = pt_count_q;
   assign busy      = busy_q;

   // Next-state and datapath updates for the four-state sequencer.
   always_comb begin
      state_d     = state_q;
      min_x_d     = min_x_q;
      min_y_d     = min_y_q;
      min_z_d     = min_z_q;
      max_x_d     = max_x_q;
      max_y_d     = max_y_q;
      max_z_d     = max_z_q;
      count_d     = count_q;
      dx_d        = dx_q;
      dy_d        = dy_q;
      dz_d        = dz_q;
      pt_count_d  = pt_count_q;
      dim_valid_d = dim_valid_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               min_x_d = pt_x;
               min_y_d = pt_y;
               min_z_d = pt_z;
               max_x_d = pt_x;
               max_y_d = pt_y;
               max_z_d = pt_z;
               count_d = {{(CNT_W-1){1'b0}}, 1'b1};
               state_d = pt_last ? CALC : ACCUM;
            end else begin
               state_d = IDLE;
            end
         end
         ACCUM: begin
            if (accept) begin
               min_x_d = smin(min_x_q, pt_x);
               min_y_d = smin(min_y_q, pt_y);
               min_z_d = smin(min_z_q, pt_z);
               max_x_d = smax(max_x_q, pt_x);
               max_y_d = smax(max_y_q, pt_y);
               max_z_d = smax(max_z_q, pt_z);
               if (count_q == {CNT_W{1'b1}}) begin
                  count_d = count_q;
               end else begin
                  count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
               end
               state_d = pt_last ? CALC : ACCUM;
            end else begin
               state_d = ACCUM;
            end
         end
         CALC: begin
            dx_d        = extent(max_x_q, min_x_q);
            dy_d        = extent(max_y_q, min_y_q);
            dz_d        = extent(max_z_q, min_z_q);
            pt_count_d  = count_q;
            dim_valid_d = 1'b1;
            state_d     = OUT;
         end
         OUT: begin
            if (dim_ready) begin
               dim_valid_d = 1'b0;
               state_d     = IDLE;
            end else begin
               dim_valid_d = 1'b1;
               state_d     = OUT;
            end
         end
         default: begin
            dim_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   // State and result registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         min_x_q     <= 32'd0;
         min_y_q     <= 32'd0;
         min_z_q     <= 32'd0;
         max_x_q     <= 32'd0;
         max_y_q     <= 32'd0;
         max_z_q     <= 32'd0;
         count_q     <= {CNT_W{1'b0}};
         dx_q        <= 32'd0;
         dy_q        <= 32'd0;
         dz_q        <= 32'd0;
         pt_count_q  <= {CNT_W{1'b0}};
         dim_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         min_x_q     <= min_x_d;
         min_y_q     <= min_y_d;
         min_z_q     <= min_z_d;
         max_x_q     <= max_x_d;
         max_y_q     <= max_y_d;
         max_z_q     <= max_z_d;
         count_q     <= count_d;
         dx_q        <= dx_d;
         dy_q        <= dy_d;
         dz_q        <= dz_d;
         pt_count_q  <= pt_count_d;
         dim_valid_q <= dim_valid_d;
         busy_q      <= (state_d != IDLE);
      end
   end

endmodule

// File: tb/tb_bbox_dim_sequencer.sv
// Randomized bench for bbox_dim_sequencer; a default-width and a 4-bit-count instance
// share the same stimulus and are checked against a queue-based extent model.
module tb_bbox_dim_sequencer;

   logic        clk = 1'b0;
   logic        rst, pt_valid, pt_last, dim_ready;
   logic [31:0] pt_x, pt_y, pt_z;
   logic        pt_ready, dim_valid, busy;
   logic [31:0] dx, dy, dz;
   logic [15:0] pt_count;
   logic        pt_ready4, dim_valid4, busy4;
   logic [31:0] dx4, dy4, dz4;
   logic [3:0]  pt_count4;

   int checks = 0;
   int errors = 0;

   logic [31:0] q_x[$];
   logic [31:0] q_y[$];
   logic [31:0] q_z[$];

   always #5 clk = ~clk;

   bbox_dim_sequencer u_dut (
      .clk(clk), .rst(rst), .pt_valid(pt_valid), .pt_ready(pt_ready),
      .pt_x(pt_x), .pt_y(pt_y), .pt_z(pt_z), .pt_last(pt_last),
      .dim_valid(dim_valid), .dim_ready(dim_ready),
      .dx(dx), .dy(dy), .dz(dz), .pt_count(pt_count), .busy(busy)
   );

   bbox_dim_sequencer #(.CNT_W(4)) u_dut4 (
      .clk(clk), .rst(rst), .pt_valid(pt_valid), .pt_ready(pt_ready4),
      .pt_x(pt_x), .pt_y(pt_y), .pt_z(pt_z), .pt_last(pt_last),
      .dim_valid(dim_valid4), .dim_ready(dim_ready),
      .dx(dx4), .dy(dy4), .dz(dz4), .pt_count(pt_count4), .busy(busy4)
   );

   // Extent of one axis over all points in the current cluster, clipped at 0x7FFFFFFF.
   function automatic logic [31:0] ref_extent(input int axis);
      longint lo, hi, v, e;
      lo = 64'sh7FFF_FFFF_FFFF_FFFF;
      hi = -64'sh7FFF_FFFF_FFFF_FFFF;
      for (int i = 0; i < q_x.size(); i++) begin
         if (axis == 0) v = longint'($signed(q_x[i]));
         else if (axis == 1) v = longint'($signed(q_y[i]));
         else v = longint'($signed(q_z[i]));
         if (v < lo) lo = v;
         if (v > hi) hi = v;
      end
      e = hi - lo;
      if (e > 64'sh7FFF_FFFF) e = 64'sh7FFF_FFFF;
      return e[31:0];
   endfunction

   function automatic longint ref_count(input longint cap);
      return (q_x.size() > cap) ? cap : longint'(q_x.size());
   endfunction

   task automatic clear_model();
      q_x.delete();
      q_y.delete();
      q_z.delete();
   endtask

   task automatic send_point(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                             input logic last, input int gap, output bit to);
      int w = 0;
      to = 1'b0;
      if (gap > 0) begin
         @(negedge clk);
         pt_valid = 1'b0;
         repeat (gap - 1) @(negedge clk);
      end
      @(negedge clk);
      pt_valid = 1'b1;
      pt_x = x;
      pt_y = y;
      pt_z = z;
      pt_last = last;
      while (!pt_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (!pt_ready) begin
         to = 1'b1;
         return;
      end
      @(posedge clk);
      q_x.push_back(x);
      q_y.push_back(y);
      q_z.push_back(z);
   endtask

   task automatic collect(input int delay, output logic [31:0] rx, output logic [31:0] ry,
                          output logic [31:0] rz, output logic [15:0] rc, output logic [3:0] rc4,
                          output bit to, output logic post_v);
      int w = 0;
      to = 1'b0;
      rx = 32'd0; ry = 32'd0; rz = 32'd0; rc = 16'd0; rc4 = 4'd0; post_v = 1'b0;
      @(negedge clk);
      while (!dim_valid && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (!dim_valid) begin
         to = 1'b1;
         return;
      end
      repeat (delay) @(negedge clk);
      rx = dx; ry = dy; rz = dz; rc = pt_count; rc4 = pt_count4;
      dim_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      dim_ready = 1'b0;
      post_v = dim_valid;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; pt_valid = 1'b0; dim_ready = 1'b0; pt_last = 1'b0;
      pt_x = 32'd0; pt_y = 32'd0; pt_z = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      pt_valid = 1'b1;
      #1;
      checks++;
      if (pt_ready !== 1'b0 || pt_ready4 !== 1'b0) begin
         errors++; $display("FAIL reset_pt_ready got %b/%b want 0", pt_ready, pt_ready4);
      end
      checks++;
      if (dim_valid !== 1'b0 || busy !== 1'b0 || busy4 !== 1'b0) begin
         errors++; $display("FAIL reset_flags dim_valid %b busy %b/%b want 0", dim_valid, busy, busy4);
      end
      checks++;
      if (dx !== 32'd0 || dy !== 32'd0 || dz !== 32'd0 || pt_count !== 16'd0) begin
         errors++; $display("FAIL reset_outputs got %h %h %h %0d want 0", dx, dy, dz, pt_count);
      end
      pt_valid = 1'b0;
      rst = 1'b0;
      #1;
      checks++;
      if (pt_ready !== 1'b1) begin
         errors++; $display("FAIL reset_release_ready got %b want 1", pt_ready);
      end
   endtask

   task automatic test_spec_vectors();
      bit to;
      logic [31:0] rx, ry, rz;
      logic [15:0] rc;
      logic [3:0] rc4;
      logic pv;
      clear_model();
      send_point(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 1'b0, 0, to);
      send_point(32'hFFFF_0000, 32'h0005_0000, 32'h0003_0000, 1'b0, 0, to);
      send_point(32'h0004_0000, 32'hFFFE_0000, 32'h0000_8000, 1'b1, 0, to);
      checks++;
      if (to) begin errors++; $display("FAIL vec3_accept timeout"); end
      @(negedge clk);
      pt_valid = 1'b0;
      checks++;
      if (dim_valid !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL vec3_calc_cycle dim_valid %b busy %b want 0 1", dim_valid, busy);
      end
      @(negedge clk);
      checks++;
      if (dim_valid !== 1'b1) begin
         errors++; $display("FAIL vec3_latency dim_valid %b want 1", dim_valid);
      end
      checks++;
      if (dx !== 32'h0005_0000 || dy !== 32'h0007_0000 || dz !== 32'h0002_8000 || pt_count !== 16'd3) begin
         errors++; $display("FAIL vec3_values got %h %h %h %0d want 00050000 00070000 00028000 3", dx, dy, dz, pt_count);
      end
      checks++;
      if (dx !== ref_extent(0) || dy !== ref_extent(1) || dz !== ref_extent(2)) begin
         errors++; $display("FAIL vec3_model got %h %h %h want %h %h %h", dx, dy, dz, ref_extent(0), ref_extent(1), ref_extent(2));
      end
      dim_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      dim_ready = 1'b0;
      checks++;
      if (dim_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL vec3_release dim_valid %b busy %b want 0 0", dim_valid, busy);
      end

      clear_model();
      send_point(32'h0007_0000, 32'h0007_0000, 32'h0007_0000, 1'b1, 0, to);
      @(negedge clk);
      pt_valid = 1'b0;
      collect(0, rx, ry, rz, rc, rc4, to, pv);
      checks++;
      if (to || rx !== 32'd0 || ry !== 32'd0 || rz !== 32'd0 || rc !== 16'd1 || pv !== 1'b0) begin
         errors++; $display("FAIL single_point to %b got %h %h %h %0d post %b want 0 0 0 1 0", to, rx, ry, rz, rc, pv);
      end

      clear_model();
      send_point(32'h7FFF_0000, 32'd0, 32'd0, 1'b0, 0, to);
      send_point(32'h8000_0000, 32'd0, 32'd0, 1'b1, 0, to);
      @(negedge clk);
      pt_valid = 1'b0;
      collect(1, rx, ry, rz, rc, rc4, to, pv);
      checks++;
      if (to || rx !== 32'h7FFF_FFFF || ry !== 32'd0 || rc !== 16'd2) begin
         errors++; $display("FAIL saturate_extent to %b got %h %h %0d want 7fffffff 0 2", to, rx, ry, rc);
      end
   endtask

   task automatic test_backpressure();
      bit to;
      logic [31:0] hx, hy, hz, rx, ry, rz;
      logic [15:0] hc, rc;
      logic [3:0] rc4;
      logic pv;
      clear_model();
      send_point($urandom, $urandom, $urandom, 1'b0, 0, to);
      send_point($urandom, $urandom, $urandom, 1'b1, 0, to);
      hx = ref_extent(0); hy = ref_extent(1); hz = ref_extent(2); hc = 16'd2;
      @(negedge clk);
      pt_valid = 1'b1; pt_x = 32'h0123_4567; pt_y = 32'h89AB_CDEF; pt_z = 32'h0000_0001; pt_last = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (dim_valid !== 1'b1 || pt_ready !== 1'b0 || busy !== 1'b1 ||
             dx !== hx || dy !== hy || dz !== hz || pt_count !== hc) begin
            errors++;
            $display("FAIL hold_out cyc %0d valid %b ready %b got %h %h %h %0d want %h %h %h %0d",
                     i, dim_valid, pt_ready, dx, dy, dz, pt_count, hx, hy, hz, hc);
         end
         @(negedge clk);
      end
      dim_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      dim_ready = 1'b0;
      checks++;
      if (dim_valid !== 1'b0 || pt_ready !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL idle_return valid %b ready %b busy %b want 0 1 0", dim_valid, pt_ready, busy);
      end
      @(posedge clk);
      @(negedge clk);
      pt_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || pt_ready !== 1'b0) begin
         errors++; $display("FAIL held_point_accept busy %b ready %b want 1 0", busy, pt_ready);
      end
      collect(0, rx, ry, rz, rc, rc4, to, pv);
      checks++;
      if (to || rx !== 32'd0 || ry !== 32'd0 || rz !== 32'd0 || rc !== 16'd1) begin
         errors++; $display("FAIL held_point_result to %b got %h %h %h %0d want 0 0 0 1", to, rx, ry, rz, rc);
      end
   endtask

   task automatic test_reset_mid();
      bit to;
      logic [31:0] rx, ry, rz;
      logic [15:0] rc;
      logic [3:0] rc4;
      logic pv;
      int seen;
      clear_model();
      send_point($urandom, $urandom, $urandom, 1'b0, 0, to);
      send_point($urandom, $urandom, $urandom, 1'b0, 0, to);
      @(negedge clk);
      pt_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (dim_valid !== 1'b0 || busy !== 1'b0) seen++;
         @(negedge clk);
      end
      checks++;
      if (seen != 0) begin errors++; $display("FAIL mid_reset_discard active cycles %0d want 0", seen); end

      clear_model();
      send_point($urandom, $urandom, $urandom, 1'b0, 0, to);
      send_point($urandom, $urandom, $urandom, 1'b1, 0, to);
      @(negedge clk);
      pt_valid = 1'b0;
      collect(0, rx, ry, rz, rc, rc4, to, pv);
      checks++;
      if (to || rc !== 16'd2 || rx !== ref_extent(0) || ry !== ref_extent(1) || rz !== ref_extent(2)) begin
         errors++; $display("FAIL post_reset_cluster to %b got %h %h %h %0d want %h %h %h 2",
                            to, rx, ry, rz, rc, ref_extent(0), ref_extent(1), ref_extent(2));
      end

      clear_model();
      send_point(32'h0000_1000, 32'd0, 32'd0, 1'b1, 0, to);
      @(negedge clk);
      pt_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (dim_valid !== 1'b1) begin errors++; $display("FAIL out_before_reset valid %b want 1", dim_valid); end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         if (dim_valid !== 1'b0) seen++;
         @(negedge clk);
      end
      checks++;
      if (seen != 0) begin errors++; $display("FAIL out_reset_discard valid cycles %0d want 0", seen); end
   endtask

   task automatic test_count_saturation();
      bit to, any_to;
      logic [31:0] rx, ry, rz;
      logic [15:0] rc;
      logic [3:0] rc4;
      logic pv;
      clear_model();
      any_to = 1'b0;
      for (int i = 0; i < 20; i++) begin
         send_point($urandom, $urandom, $urandom, (i == 19), 0, to);
         any_to |= to;
      end
      @(negedge clk);
      pt_valid = 1'b0;
      collect(0, rx, ry, rz, rc, rc4, to, pv);
      checks++;
      if (any_to || to || rc !== 16'(ref_count(65535)) || rc4 !== 4'(ref_count(15))) begin
         errors++; $display("FAIL count_sat to %b got %0d/%0d want %0d/%0d", to, rc, rc4, ref_count(65535), ref_count(15));
      end
      checks++;
      if (rx !== ref_extent(0) || ry !== ref_extent(1) || rz !== ref_extent(2)) begin
         errors++; $display("FAIL count_sat_extent got %h %h %h want %h %h %h", rx, ry, rz, ref_extent(0), ref_extent(1), ref_extent(2));
      end
   endtask

   task automatic test_random();
      bit to, any_to;
      logic [31:0] rx, ry, rz, px, py, pz;
      logic [15:0] rc;
      logic [3:0] rc4;
      logic pv;
      int n, gap;
      for (int c = 0; c < 30; c++) begin
         clear_model();
         any_to = 1'b0;
         n = $urandom_range(1, 8);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 1) == 0) begin
               px = $urandom; py = $urandom; pz = $urandom;
            end else begin
               px = {{16{1'b0}}, 16'($urandom)} - 32'h0000_8000;
               py = {{16{1'b0}}, 16'($urandom)} - 32'h0000_8000;
               pz = {{16{1'b0}}, 16'($urandom)} - 32'h0000_8000;
            end
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            send_point(px, py, pz, (i == n - 1), gap, to);
            any_to |= to;
         end
         @(negedge clk);
         pt_valid = 1'b0;
         collect($urandom_range(0, 3), rx, ry, rz, rc, rc4, to, pv);
         checks++;
         if (any_to || to || pv !== 1'b0 || rc !== 16'(ref_count(65535)) || rc4 !== 4'(ref_count(15)) ||
             rx !== ref_extent(0) || ry !== ref_extent(1) || rz !== ref_extent(2)) begin
            errors++;
            $display("FAIL random_cluster %0d to %b post %b got %h %h %h %0d want %h %h %h %0d",
                     c, to, pv, rx, ry, rz, rc, ref_extent(0), ref_extent(1), ref_extent(2), ref_count(65535));
         end
      end
   endtask

   initial begin
      rst = 1'b1; pt_valid = 1'b0; pt_last = 1'b0; dim_ready = 1'b0;
      pt_x = 32'd0; pt_y = 32'd0; pt_z = 32'd0;
      test_reset();
      test_spec_vectors();
      test_backpressure();
      test_reset_mid();
      test_count_saturation();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
